// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer
//   Serial operand loader in front of the 4-bit ALU. One debounced press of
//   step_btn latches the switches into A, then B, then the function code.
//   The ALU result and flags are captured once per operation.
//   Optional macro ACCUM_CHAIN_EN: a step out of S_EXEC copies result_q into
//   op_a and resumes at S_B, so each operation starts from the previous result.
module alu_operand_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16   // stable cycles to accept a level, >= 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [3:0] sw_in,
    input  logic       step_btn,
    input  logic [3:0] alu_result,
    input  logic [3:0] alu_flags,
    output logic [3:0] op_a,
    output logic [3:0] op_b,
    output logic [3:0] op_func,
    output logic       op_valid,
    output logic [1:0] state_out,
    output logic [3:0] result_q,
    output logic [3:0] flags_q
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_A    = 2'b00,
        S_B    = 2'b01,
        S_F    = 2'b10,
        S_EXEC = 2'b11
    } state_t;

    logic          sync0, sync1;
    logic          deb_lvl;
    logic [CW-1:0] deb_cnt;
    logic          step;
    state_t        state, state_nxt;
    logic          cap_pend;   // high during the first cycle spent in S_EXEC
    logic          ld_a, ld_b, ld_f, ld_a_res, cap;

    // Two-flop synchronizer; free-running so ena does not stall metastability settling
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
        end else begin
            sync0 <= step_btn;
            sync1 <= sync0;
        end
    end

    // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt <= '0;
            deb_lvl <= 1'b0;
        end else if (ena) begin
            if (sync1 != deb_lvl) begin
                if (deb_cnt == CNT_LAST) begin
                    deb_lvl <= sync1;
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    // Step is the rising toggle of the debounced level, aligned with that toggle
    // so the FSM advances on the same edge the level is accepted.
    assign step = ena && sync1 && !deb_lvl && (deb_cnt == CNT_LAST);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   state <= S_A;
        else if (ena) state <= state_nxt;
    end

    // Next state and register-load strobes
    always_comb begin
        state_nxt = state;
        ld_a      = 1'b0;
        ld_b      = 1'b0;
        ld_f      = 1'b0;
        ld_a_res  = 1'b0;
        cap       = 1'b0;
        case (state)
            S_A: if (step) begin
                ld_a      = 1'b1;
                state_nxt = S_B;
            end
            S_B: if (step) begin
                ld_b      = 1'b1;
                state_nxt = S_F;
            end
            S_F: if (step) begin
                ld_f      = 1'b1;
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                cap = cap_pend;
                if (step) begin
`ifdef ACCUM_CHAIN_EN
                    ld_a_res  = 1'b1;
                    state_nxt = S_B;
`else
                    state_nxt = S_A;
`endif
                end
            end
            default: state_nxt = S_A;
        endcase
    end

    // Operand and result registers; everything freezes while ena is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a     <= '0;
            op_b     <= '0;
            op_func  <= '0;
            result_q <= '0;
            flags_q  <= '0;
            cap_pend <= 1'b0;
        end else if (ena) begin
            if (ld_a)     op_a    <= sw_in;
            if (ld_a_res) op_a    <= result_q;
            if (ld_b)     op_b    <= sw_in;
            if (ld_f)     op_func <= sw_in;
            if (cap) begin
                result_q <= alu_result;
                flags_q  <= alu_flags;
            end
            cap_pend <= ld_f;
        end
    end

    assign op_valid  = (state == S_EXEC);
    assign state_out = state;

endmodule
